fmap_pingpong_sched: RTL and testbench

//  Ping-pong bank scheduler for the feature-map buffer (2 banks).
//  - Loader fills one bank while the PE array reads the other.
//  - Produces write/read enables, bank selects and word addresses for the buffer RAM.
//  - Sequences one layer of cfg_tiles tiles; no data passes through this block.

---
 rtl/fmap_sched_pkg.sv | 21 ++
 rtl/fmap_addr_counter.sv | 34 +++
 rtl/fmap_pingpong_sched.sv | 182 ++++++++++++++++++
 tb/tb_fmap_pingpong_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_sched_pkg.sv
// Shared types for the feature-map ping-pong scheduler.
//   bank_state_t : occupancy of one buffer bank as it moves through a tile
//   top_state_t  : layer-level sequencing state
package fmap_sched_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } top_state_t;

  localparam int NUM_BANKS = 2;

endpackage

// File: rtl/fmap_addr_counter.sv
// Loadable word-address up-counter with a programmable terminal count.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : force the address back to zero
//   inc      : advance one word; wraps to zero after the terminal count
//   term     : last valid address of the sequence
//   addr     : current (registered) address
//   last     : addr currently equals term
module fmap_addr_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] addr,
  output logic         last
);

  logic [W-1:0] addr_reg;

  assign last = (addr_reg == term);
  assign addr = addr_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr_reg <= '0;
    end else if (inc) begin
      addr_reg <= last ? '0 : addr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fmap_pingpong_sched.sv
// Ping-pong bank scheduler for a two-bank feature-map buffer. The loader
// fills one bank while the PE array drains the other; this block only
// generates strobes, bank selects and word addresses for one layer.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_start                : accept a layer (only while idle), latching cfg_*
//   cfg_wr_words/rd_words    : words per tile on each side (0 behaves as 1)
//   cfg_tiles                : tiles per layer
//   cfg_reread               : extra read passes per bank (FMAP_REREAD_EN only)
//   wr_valid/wr_ready/wr_en  : loader handshake and RAM write strobe
//   wr_bank, addr_wr         : registered write bank and word address
//   rd_ready/rd_en           : PE handshake and RAM read strobe
//   rd_bank, addr_rd         : registered read bank and word address
//   busy, layer_done         : layer in progress / one-cycle completion pulse
// Build option: define FMAP_REREAD_EN to add multi-pass reads per bank.
module fmap_pingpong_sched
  import fmap_sched_pkg::*;
#(
  parameter int WR_ADDR_DEPTH = 10,
  parameter int RD_ADDR_DEPTH = 8,
  parameter int TILE_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [WR_ADDR_DEPTH:0]   cfg_wr_words,
  input  logic [RD_ADDR_DEPTH:0]   cfg_rd_words,
  input  logic [TILE_W-1:0]        cfg_tiles,
`ifdef FMAP_REREAD_EN
  input  logic [3:0]               cfg_reread,
`endif
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     wr_en,
  output logic                     wr_bank,
  output logic [WR_ADDR_DEPTH-1:0] addr_wr,
  input  logic                     rd_ready,
  output logic                     rd_en,
  output logic                     rd_bank,
  output logic [RD_ADDR_DEPTH-1:0] addr_rd,
  output logic                     busy,
  output logic                     layer_done
);

  top_state_t               state_reg, state_next;
  logic                     start_accept;
  logic [TILE_W-1:0]        cfg_tiles_reg, wr_tiles_reg, rd_tiles_reg;
  logic [WR_ADDR_DEPTH-1:0] wr_term_reg, wr_term_next;
  logic [RD_ADDR_DEPTH-1:0] rd_term_reg, rd_term_next;
  logic                     wr_ptr_reg, rd_ptr_reg;
  logic                     wr_last, rd_last, final_pass, rd_tile_last;
  bank_state_t              bank_st [NUM_BANKS];

  assign start_accept = (state_reg == IDLE) && cfg_start;

  // A word count of zero is treated as a one-word tile.
  assign wr_term_next = (cfg_wr_words == '0) ? '0 : WR_ADDR_DEPTH'(cfg_wr_words - 1'b1);
  assign rd_term_next = (cfg_rd_words == '0) ? '0 : RD_ADDR_DEPTH'(cfg_rd_words - 1'b1);

  assign wr_ready = (state_reg == RUN)
                  && (bank_st[wr_ptr_reg] == EMPTY || bank_st[wr_ptr_reg] == FILLING)
                  && (wr_tiles_reg < cfg_tiles_reg);
  assign wr_en    = wr_valid && wr_ready;
  assign rd_en    = (state_reg == RUN)
                  && (bank_st[rd_ptr_reg] == FULL || bank_st[rd_ptr_reg] == DRAINING)
                  && rd_ready;

  // Tile is finished on the read side only when the last word of the final pass goes out.
  assign rd_tile_last = rd_en && rd_last && final_pass;

`ifdef FMAP_REREAD_EN
  logic [3:0] reread_reg, pass_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      reread_reg <= '0;
      pass_reg   <= '0;
    end else if (start_accept) begin
      reread_reg <= cfg_reread;
      pass_reg   <= '0;
    end else if (rd_en && rd_last) begin
      pass_reg <= final_pass ? '0 : pass_reg + 1'b1;
    end
  end

  assign final_pass = (pass_reg == reread_reg);
`else
  assign final_pass = 1'b1;
`endif

  fmap_addr_counter #(.W(WR_ADDR_DEPTH)) u_wr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_accept),
    .inc  (wr_en),
    .term (wr_term_reg),
    .addr (addr_wr),
    .last (wr_last)
  );

  // The read counter wraps on every pass; the bank only empties after the final one.
  fmap_addr_counter #(.W(RD_ADDR_DEPTH)) u_rd_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_accept),
    .inc  (rd_en),
    .term (rd_term_reg),
    .addr (addr_rd),
    .last (rd_last)
  );

  // Per-bank occupancy. Write and read can never hit the same bank in one
  // cycle (their qualifying states are disjoint), so both updates always apply.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    bank_state_t st_reg;
    logic        wr_hit, rd_hit;

    assign wr_hit = wr_en && (wr_ptr_reg == 1'(gi));
    assign rd_hit = rd_en && (rd_ptr_reg == 1'(gi));

    always_ff @(posedge clk) begin
      if (rst || start_accept) begin
        st_reg <= EMPTY;
      end else if (wr_hit) begin
        st_reg <= wr_last ? FULL : FILLING;
      end else if (rd_hit) begin
        st_reg <= rd_tile_last ? EMPTY : DRAINING;
      end
    end

    assign bank_st[gi] = st_reg;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (cfg_start) state_next = (cfg_tiles == '0) ? DONE : RUN;
      RUN:     if (rd_tiles_reg == cfg_tiles_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cfg_tiles_reg <= '0;
      wr_term_reg   <= '0;
      rd_term_reg   <= '0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      wr_tiles_reg  <= '0;
      rd_tiles_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start_accept) begin
        cfg_tiles_reg <= cfg_tiles;
        wr_term_reg   <= wr_term_next;
        rd_term_reg   <= rd_term_next;
        wr_ptr_reg    <= 1'b0;
        rd_ptr_reg    <= 1'b0;
        wr_tiles_reg  <= '0;
        rd_tiles_reg  <= '0;
      end else begin
        if (wr_en && wr_last) begin
          wr_ptr_reg   <= ~wr_ptr_reg;
          wr_tiles_reg <= wr_tiles_reg + 1'b1;
        end
        if (rd_tile_last) begin
          rd_ptr_reg   <= ~rd_ptr_reg;
          rd_tiles_reg <= rd_tiles_reg + 1'b1;
        end
      end
    end
  end

  assign wr_bank    = wr_ptr_reg;
  assign rd_bank    = rd_ptr_reg;
  assign busy       = (state_reg != IDLE);
  assign layer_done = (state_reg == DONE);

endmodule

// File: tb/tb_fmap_pingpong_sched.sv
// Self-checking bench for fmap_pingpong_sched. The reference model tracks
// the layer purely as tile/word counts: tile k lives in bank k%2, may be
// written once tile k-2 has been fully read, and may be read once it has
// been fully written. One line is printed per layer.
module tb_fmap_pingpong_sched;

  localparam int WRW  = 10;
  localparam int RDW  = 8;
  localparam int TW   = 16;
  localparam int MAXC = 3000;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start;
  logic [WRW:0]    cfg_wr_words;
  logic [RDW:0]    cfg_rd_words;
  logic [TW-1:0]   cfg_tiles;
`ifdef FMAP_REREAD_EN
  logic [3:0]      cfg_reread;
`endif
  logic            wr_valid, wr_ready, wr_en, wr_bank;
  logic [WRW-1:0]  addr_wr;
  logic            rd_ready, rd_en, rd_bank;
  logic [RDW-1:0]  addr_rd;
  logic            busy, layer_done;

  fmap_pingpong_sched #(.WR_ADDR_DEPTH(WRW), .RD_ADDR_DEPTH(RDW), .TILE_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_wr_words (cfg_wr_words),
    .cfg_rd_words (cfg_rd_words),
    .cfg_tiles    (cfg_tiles),
`ifdef FMAP_REREAD_EN
    .cfg_reread   (cfg_reread),
`endif
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .addr_wr      (addr_wr),
    .rd_ready     (rd_ready),
    .rd_en        (rd_en),
    .rd_bank      (rd_bank),
    .addr_rd      (addr_rd),
    .busy         (busy),
    .layer_done   (layer_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  // Reference model state: phase 0=idle 1=running 2=done.
  int m_phase, m_tiles, m_wlast, m_rlast, m_reread;
  int m_wt, m_wc, m_rt, m_rc, m_pass;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_wr_ready();
    return (m_phase == 1) && (m_wt < m_tiles) && ((m_wt - m_rt) < 2);
  endfunction

  function automatic bit exp_rd_en();
    return (m_phase == 1) && (m_rt < m_wt) && rd_ready;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_tiles = 0; m_wlast = 0; m_rlast = 0; m_reread = 0;
    m_wt = 0; m_wc = 0; m_rt = 0; m_rc = 0; m_pass = 0;
  endtask

  task automatic model_step();
    bit wf, rf;
    int old_rt;
    if (rst) begin
      model_reset();
      return;
    end
    wf = wr_valid && exp_wr_ready();
    rf = exp_rd_en();
    old_rt = m_rt;
    if (wf) begin
      if (m_wc == m_wlast) begin m_wc = 0; m_wt++; end
      else m_wc++;
    end
    if (rf) begin
      if (m_rc == m_rlast) begin
        m_rc = 0;
        if (m_pass == m_reread) begin m_pass = 0; m_rt++; end
        else m_pass++;
      end else m_rc++;
    end
    case (m_phase)
      0: if (cfg_start) begin
        m_tiles = int'(cfg_tiles);
        m_wlast = (cfg_wr_words == 0) ? 0 : int'(cfg_wr_words) - 1;
        m_rlast = (cfg_rd_words == 0) ? 0 : int'(cfg_rd_words) - 1;
`ifdef FMAP_REREAD_EN
        m_reread = int'(cfg_reread);
`else
        m_reread = 0;
`endif
        m_wt = 0; m_wc = 0; m_rt = 0; m_rc = 0; m_pass = 0;
        m_phase = (m_tiles == 0) ? 2 : 1;
      end
      1: if (old_rt == m_tiles) m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    check("wr_ready",   int'(wr_ready),   int'(exp_wr_ready()));
    check("wr_en",      int'(wr_en),      int'(wr_valid && exp_wr_ready()));
    check("wr_bank",    int'(wr_bank),    m_wt % 2);
    check("addr_wr",    int'(addr_wr),    m_wc);
    check("rd_en",      int'(rd_en),      int'(exp_rd_en()));
    check("rd_bank",    int'(rd_bank),    m_rt % 2);
    check("addr_rd",    int'(addr_rd),    m_rc);
    check("busy",       int'(busy),       int'(m_phase != 0));
    check("layer_done", int'(layer_done), int'(m_phase == 2));
    if (layer_done) done_seen++;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  int layer_no = 0;

  task automatic run_layer(input int tiles, input int ww, input int rw, input int rr,
                           input int vprob, input int rprob, input int hold_rd,
                           input int rst_at, input bit junk);
    int  cyc;
    bit  aborted;
    done_seen = 0;
    aborted   = 1'b0;
    cfg_start    = 1'b1;
    cfg_tiles    = TW'(tiles);
    cfg_wr_words = (WRW+1)'(ww);
    cfg_rd_words = (RDW+1)'(rw);
`ifdef FMAP_REREAD_EN
    cfg_reread   = 4'(rr);
`endif
    wr_valid = ($urandom_range(0, 99) < vprob);
    rd_ready = (hold_rd > 0) ? 1'b0 : ($urandom_range(0, 99) < rprob);
    tick();
    cfg_start = 1'b0;
    cyc = 1;
    while (m_phase != 0 && cyc < MAXC) begin
      rst = (cyc == rst_at);
      // Starts arriving while a layer is active must be ignored.
      cfg_start = junk && ($urandom_range(0, 5) == 0);
      if (cfg_start) begin
        cfg_tiles    = TW'($urandom_range(0, 9));
        cfg_wr_words = (WRW+1)'($urandom_range(0, 9));
        cfg_rd_words = (RDW+1)'($urandom_range(0, 9));
      end
      wr_valid = ($urandom_range(0, 99) < vprob);
      rd_ready = (cyc < hold_rd) ? 1'b0 : ($urandom_range(0, 99) < rprob);
      tick();
      if (rst) aborted = 1'b1;
      rst = 1'b0;
      cfg_start = 1'b0;
      cyc++;
    end
    check("timeout", int'(cyc < MAXC), 1);
    check("done_pulses", done_seen, aborted ? 0 : 1);
    check("idle_after", int'(busy), 0);
    $display("layer %0d tiles=%0d wr_words=%0d rd_words=%0d reread=%0d cycles=%0d aborted=%0d done_pulses=%0d",
             layer_no, tiles, ww, rw, rr, cyc, aborted, done_seen);
    layer_no++;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_wr_words = '0; cfg_rd_words = '0; cfg_tiles = '0;
`ifdef FMAP_REREAD_EN
    cfg_reread = '0;
`endif
    wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Two tiles, 4 writes / 2 reads, everything always ready.
    run_layer(2, 4, 2, 0, 100, 100, 0, -1, 1'b0);
    // Reader held off: both banks fill and the writer stalls.
    run_layer(3, 4, 2, 0, 100, 100, 14, -1, 1'b0);
    // Empty layer: straight to the done pulse.
    run_layer(0, 4, 2, 0, 100, 100, 0, -1, 1'b0);
    // Reset while the write address is at 2, then a clean restart.
    run_layer(2, 4, 2, 0, 100, 100, 0, 3, 1'b0);
    run_layer(2, 4, 2, 0, 100, 100, 0, -1, 1'b0);
    // Stray starts during the layer, and zero word counts.
    run_layer(3, 3, 5, 0, 100, 100, 0, -1, 1'b1);
    run_layer(3, 0, 0, 0, 100, 100, 0, -1, 1'b1);
    // Multi-pass reads (only effective when the option is built in).
    run_layer(2, 2, 3, 1, 100, 100, 0, -1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      run_layer($urandom_range(1, 5), $urandom_range(0, 6), $urandom_range(0, 6),
                $urandom_range(0, 2), $urandom_range(30, 100), $urandom_range(30, 100),
                $urandom_range(0, 10), -1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
